// File: rtl/fft_frame_loader.sv
// fft_frame_loader: packs a valid/ready sample stream into 8-sample frames
// in bit-reversed (or natural) slot order and holds each frame for the FFT.
// Ports: clk_1, reset (sync, high); s_valid/s_data/s_sof/s_ready stream in;
//        frame_valid/frame_ack + out1..out8 frame out; drop_cnt resync count.
module fft_frame_loader #(
  parameter int WIDTH       = 8,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic             clk_1,
  input  logic             reset,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_sof,
  output logic             s_ready,
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [7:0]       drop_cnt
);

  typedef enum logic {
    ST_FILL,
    ST_WAIT
  } state_t;

  state_t           state;
  logic [2:0]       widx;
  logic [WIDTH-1:0] fbuf [8];
  logic [WIDTH-1:0] outr [8];

  logic       accept;
  logic       resync;
  logic       free;
  logic       last;
  logic [2:0] idx;
  logic [2:0] slot;

  assign s_ready = (state == ST_FILL);
  assign accept  = s_valid && s_ready;
  assign resync  = s_sof && (widx != 3'd0);
  // A start-of-frame always restarts at index 0.
  assign idx     = s_sof ? 3'd0 : widx;
  assign slot    = BIT_REVERSE ? {idx[0], idx[1], idx[2]} : idx;
  assign free    = !frame_valid || frame_ack;
  assign last    = (idx == 3'd7);

  assign out1 = outr[0];
  assign out2 = outr[1];
  assign out3 = outr[2];
  assign out4 = outr[3];
  assign out5 = outr[4];
  assign out6 = outr[5];
  assign out7 = outr[6];
  assign out8 = outr[7];

  always_ff @(posedge clk_1) begin
    if (reset) begin
      state       <= ST_FILL;
      widx        <= 3'd0;
      frame_valid <= 1'b0;
      drop_cnt    <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        fbuf[i] <= '0;
        outr[i] <= '0;
      end
    end else begin
      // Consumed frame with no replacement; overridden below on a load.
      if (frame_valid && frame_ack)
        frame_valid <= 1'b0;
      unique case (state)
        ST_FILL: begin
          if (accept) begin
            if (resync && drop_cnt != 8'hff)
              drop_cnt <= drop_cnt + 8'd1;
            if (last && free) begin
              // Bypass: last sample goes straight to the output.
              for (int i = 0; i < 8; i++)
                outr[i] <= fbuf[i];
              outr[slot]  <= s_data;
              frame_valid <= 1'b1;
              widx        <= 3'd0;
            end else begin
              fbuf[slot] <= s_data;
              widx       <= idx + 3'd1;
              if (last)
                state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (free) begin
            outr        <= fbuf;
            frame_valid <= 1'b1;
            widx        <= 3'd0;
            state       <= ST_FILL;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader: scoreboard bench for fft_frame_loader.
// Queue-based frame model feeds expected frames; a monitor checks them.
module tb_fft_frame_loader;

  logic       clk_1 = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_sof = 1'b0;
  logic       s_ready;
  logic       frame_valid;
  logic       frame_ack = 1'b0;
  logic [7:0] out1, out2, out3, out4, out5, out6, out7, out8;
  logic [7:0] drop_cnt;

  logic       rst0 = 1'b1;
  logic       v0 = 1'b0;
  logic [7:0] d0 = 8'd0;
  logic       sof0 = 1'b0;
  logic       rdy0;
  logic       fv0;
  logic       ack0 = 1'b0;
  logic [7:0] o1, o2, o3, o4, o5, o6, o7, o8;
  logic [7:0] dc0;

  fft_frame_loader #(.WIDTH(8), .BIT_REVERSE(1'b1)) dut (
    .clk_1(clk_1), .reset(reset),
    .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof),
    .s_ready(s_ready), .frame_valid(frame_valid),
    .frame_ack(frame_ack),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .out5(out5), .out6(out6), .out7(out7), .out8(out8),
    .drop_cnt(drop_cnt)
  );

  fft_frame_loader #(.WIDTH(8), .BIT_REVERSE(1'b0)) dut0 (
    .clk_1(clk_1), .reset(rst0),
    .s_valid(v0), .s_data(d0), .s_sof(sof0),
    .s_ready(rdy0), .frame_valid(fv0),
    .frame_ack(ack0),
    .out1(o1), .out2(o2), .out3(o3), .out4(o4),
    .out5(o5), .out6(o6), .out7(o7), .out8(o8),
    .drop_cnt(dc0)
  );

  always #5 clk_1 = ~clk_1;

  int compares = 0;
  int errors = 0;
  int ack_mode = 0;
  int gaps = 0;
  bit watch = 0;
  bit pfv = 0;
  bit pack = 0;
  int mdrops = 0;
  int ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [7:0]  part [$];
  logic [63:0] expq [$];

  wire [63:0] act = {out1, out2, out3, out4, out5, out6, out7, out8};
  wire [63:0] act0 = {o1, o2, o3, o4, o5, o6, o7, o8};

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    compares++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // Reference: collect samples, resync on sof, emit reordered frames.
  task automatic model_accept(logic [7:0] d, logic sof);
    logic [63:0] f;
    if (sof && part.size() != 0) begin
      part.delete();
      if (mdrops < 255) mdrops++;
    end
    part.push_back(d);
    if (part.size() == 8) begin
      for (int k = 0; k < 8; k++)
        f[63-8*k -: 8] = part[ord[k]];
      expq.push_back(f);
      part.delete();
    end
  endtask

  // Called and returns at posedge+1.
  task automatic send(logic [7:0] d, logic sof, output int stalls);
    bit ok = 0;
    int n = 0;
    s_valid = 1'b1; s_data = d; s_sof = sof;
    while (!ok && n < 64) begin
      @(negedge clk_1); ok = s_ready;
      @(posedge clk_1);
      if (!ok) n++;
    end
    if (ok) model_accept(d, sof);
    else chk("send_timeout", 64'(n), 64'd0);
    #1; s_valid = 1'b0; s_sof = 1'b0;
    stalls = n;
  endtask

  task automatic send0(logic [7:0] d, logic sof);
    bit ok = 0;
    int n = 0;
    v0 = 1'b1; d0 = d; sof0 = sof;
    while (!ok && n < 64) begin
      @(negedge clk_1); ok = rdy0;
      @(posedge clk_1);
      if (!ok) n++;
    end
    if (!ok) chk("send0_timeout", 64'(n), 64'd0);
    #1; v0 = 1'b0; sof0 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; s_valid = 1'b1; s_data = 8'($urandom);
    repeat (2) @(posedge clk_1);
    #1; reset = 1'b0; s_valid = 1'b0;
    part.delete(); expq.delete(); mdrops = 0;
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    @(posedge clk_1);
    #1; rst0 = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk_1);
    #1;
  endtask

  always @(posedge clk_1) begin
    #1;
    case (ack_mode)
      0: frame_ack = 1'b0;
      1: frame_ack = 1'b1;
      2: frame_ack = 1'($urandom % 2);
      default: ;
    endcase
  end

  // Monitor: a frame is new when valid follows no-frame or an ack.
  always @(negedge clk_1) begin
    logic [63:0] e;
    if (frame_valid && (!pfv || pack)) begin
      if (expq.size() == 0) begin
        chk("unexpected_frame", act, 64'd0);
      end else begin
        e = expq.pop_front();
        chk("frame", act, e);
      end
    end
    if (watch && !frame_valid) gaps++;
    pfv = frame_valid;
    pack = frame_ack;
  end

  localparam logic [63:0] F0 = 64'h0004020601050307;
  localparam logic [63:0] F1 = 64'h080c0a0e090d0b0f;

  initial begin
    int st;
    int tot;
    logic sof;
    ack_mode = 3;

    do_reset();
    #0 rst0 = 1'b0;
    @(negedge clk_1);
    chk("rst_out", act, 64'd0);
    chk("rst_fv", 64'(frame_valid), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd1);
    @(posedge clk_1); #1;

    // Natural-order instance.
    for (int i = 0; i < 8; i++) send0(8'(i), i == 0);
    @(negedge clk_1);
    chk("nat_frame", act0, 64'h0001020304050607);
    chk("nat_fv", 64'(fv0), 64'd1);
    @(posedge clk_1); #1;
    reset0();
    for (int i = 0; i < 5; i++) send0(8'(20 + i), i == 0);
    reset0();
    for (int i = 0; i < 7; i++) send0(8'(30 + i), i == 0);
    @(negedge clk_1);
    chk("nat_rst_fv", 64'(fv0), 64'd0);
    @(posedge clk_1); #1;
    send0(8'd37, 1'b0);
    @(negedge clk_1);
    chk("nat_clean", act0, 64'h1e1f202122232425);
    @(posedge clk_1); #1;

    // Fill, then hold while the next frame waits.
    frame_ack = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(i), i == 0, st);
    @(negedge clk_1);
    chk("f0_fv", 64'(frame_valid), 64'd1);
    chk("f0_out", act, F0);
    @(posedge clk_1); #1;
    for (int i = 8; i < 16; i++) send(8'(i), i == 8, st);
    @(negedge clk_1);
    chk("wait_ready", 64'(s_ready), 64'd0);
    chk("wait_hold", act, F0);
    frame_ack = 1'b1;
    @(posedge clk_1); #1;
    frame_ack = 1'b0;
    @(negedge clk_1);
    chk("xfer_out", act, F1);
    chk("xfer_fv", 64'(frame_valid), 64'd1);
    chk("xfer_ready", 64'(s_ready), 64'd1);
    @(posedge clk_1); #1;

    // Ack tied high: full rate.
    ack_mode = 1;
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      send(8'(i), i == 0 || i == 8, st);
      tot += st;
    end
    @(negedge clk_1);
    chk("rate_stalls", 64'(tot), 64'd0);
    chk("rate_fv", 64'(frame_valid), 64'd1);
    chk("rate_out", act, F1);
    @(posedge clk_1); #1;
    idle(2);

    // Ack coincident with the 8th sample: no gap.
    ack_mode = 3; frame_ack = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(i), i == 0, st);
    watch = 1; gaps = 0;
    for (int i = 8; i < 15; i++) send(8'(i), 1'b0, st);
    frame_ack = 1'b1;
    send(8'd15, 1'b0, st);
    frame_ack = 1'b0;
    @(negedge clk_1);
    watch = 0;
    chk("nogap_cnt", 64'(gaps), 64'd0);
    chk("nogap_out", act, F1);
    @(posedge clk_1); #1;

    // Resync drops, saturating.
    ack_mode = 1;
    for (int r = 0; r < 300; r++) begin
      for (int i = 0; i < 3; i++) send(8'(100 + i), i == 0, st);
      for (int i = 0; i < 8; i++) send(8'(i), i == 0, st);
      if (r == 0) begin
        @(negedge clk_1);
        chk("drop_one", 64'(drop_cnt), 64'(mdrops));
        @(posedge clk_1); #1;
      end
    end
    @(negedge clk_1);
    chk("drop_sat", 64'(drop_cnt), 64'd255);
    @(posedge clk_1); #1;

    // Reset while a frame is held and another waits.
    ack_mode = 3; frame_ack = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(200 + i), i % 8 == 0, st);
    do_reset();
    @(negedge clk_1);
    chk("rst2_fv", 64'(frame_valid), 64'd0);
    chk("rst2_out", act, 64'd0);
    chk("rst2_drop", 64'(drop_cnt), 64'd0);
    chk("rst2_ready", 64'(s_ready), 64'd1);
    @(posedge clk_1); #1;

    // Random traffic.
    ack_mode = 2;
    for (int n = 0; n < 400; n++) begin
      if ($urandom % 4 == 0) idle(1 + $urandom % 3);
      if (part.size() == 0) sof = 1'($urandom % 2);
      else sof = ($urandom % 16 == 0);
      send(8'($urandom), sof, st);
    end
    ack_mode = 1;
    idle(20);
    @(negedge clk_1);
    chk("drain_empty", 64'(expq.size()), 64'd0);
    chk("rand_drop", 64'(drop_cnt), 64'(mdrops));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compares, errors);
    $finish;
  end

endmodule
